// File: rtl/clock_pkg.sv
// Shared types and BCD limits for the Century Clock time-setting path.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    COMMIT   = 2'b11
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  localparam logic [1:0] HOUR_MAX_10     = 2'd2;
  localparam logic [3:0] HOUR_MAX_1_AT_2 = 4'd3;
  localparam logic [2:0] MIN_MAX_10      = 3'd5;
  localparam logic [3:0] DIGIT_MAX       = 4'd9;

  function automatic logic hours_ok(
    input logic [1:0] t,
    input logic [3:0] u
  );
    return (t < HOUR_MAX_10 && u <= DIGIT_MAX) ||
           (t == HOUR_MAX_10 && u <= HOUR_MAX_1_AT_2);
  endfunction

  function automatic logic mins_ok(
    input logic [2:0] t,
    input logic [3:0] u
  );
    return (t <= MIN_MAX_10) && (u <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_inc2.sv
// Two-digit BCD +1 with wrap to 00 at a fixed value.
module bcd_inc2
  import clock_pkg::*;
#(
  parameter int            TW      = 4,
  parameter logic [TW-1:0] WRAP_10 = '0,
  parameter logic [3:0]    WRAP_1  = '0
) (
  input  logic [TW-1:0] tens,
  input  logic [3:0]    units,
  output logic [TW-1:0] tens_nx,
  output logic [3:0]    units_nx
);

  localparam logic [TW-1:0] ONE = 1;

  always_comb begin
    tens_nx  = tens;
    units_nx = units + 4'd1;
    if (tens == WRAP_10 && units == WRAP_1) begin
      tens_nx  = '0;
      units_nx = '0;
    end else if (units >= DIGIT_MAX) begin
      tens_nx  = tens + ONE;
      units_nx = '0;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting FSM: freezes the counters, edits a BCD shadow,
// and strobes it back into the counter chain on commit.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_hours_10,
  input  logic [3:0] cur_hours_1,
  input  logic [2:0] cur_minutes_10,
  input  logic [3:0] cur_minutes_1,
  output logic       run_en,
  output logic       load,
  output logic [1:0] ld_hours_10,
  output logic [3:0] ld_hours_1,
  output logic [2:0] ld_minutes_10,
  output logic [3:0] ld_minutes_1,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_S - 1);

  state_t     state, state_n;
  logic       mode_q, inc_q;
  logic       mode_ev, inc_ev;
  logic       setting, setting_n;
  logic       timeout;
  logic [7:0] cnt;
  logic [1:0] h10_nx;
  logic [3:0] h1_nx;
  logic [2:0] m10_nx;
  logic [3:0] m1_nx;

  // mode wins a same-cycle tie with inc
  assign mode_ev = btn_mode & ~mode_q;
  assign inc_ev  = btn_inc & ~inc_q & ~mode_ev;

  assign setting   = (state == SET_HOUR) || (state == SET_MIN);
  assign setting_n = (state_n == SET_HOUR) || (state_n == SET_MIN);
  assign timeout   = tick_1hz && !inc_ev && (cnt == LIMIT);

  bcd_inc2 #(
    .TW      (2),
    .WRAP_10 (HOUR_MAX_10),
    .WRAP_1  (HOUR_MAX_1_AT_2)
  ) u_hour_inc (
    .tens     (ld_hours_10),
    .units    (ld_hours_1),
    .tens_nx  (h10_nx),
    .units_nx (h1_nx)
  );

  bcd_inc2 #(
    .TW      (3),
    .WRAP_10 (MIN_MAX_10),
    .WRAP_1  (DIGIT_MAX)
  ) u_min_inc (
    .tens     (ld_minutes_10),
    .units    (ld_minutes_1),
    .tens_nx  (m10_nx),
    .units_nx (m1_nx)
  );

  always_comb begin
    state_n   = state;
    run_en    = 1'b0;
    load      = 1'b0;
    field_sel = FIELD_NONE;
    unique case (state)
      RUN: begin
        run_en = 1'b1;
        if (mode_ev) state_n = SET_HOUR;
      end
      SET_HOUR: begin
        field_sel = FIELD_HOUR;
        if (mode_ev)      state_n = SET_MIN;
        else if (timeout) state_n = RUN;
      end
      SET_MIN: begin
        field_sel = FIELD_MIN;
        if (mode_ev)      state_n = COMMIT;
        else if (timeout) state_n = RUN;
      end
      COMMIT: begin
        load    = 1'b1;
        state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mode_q <= 1'b0;
      inc_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!setting || state_n != state || mode_ev || inc_ev) begin
      cnt <= '0;
    end else if (tick_1hz) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b0;
    end else if (setting && setting_n) begin
      if (tick_1hz) blink <= ~blink;
    end else begin
      blink <= 1'b0;
    end
  end

  // out-of-range live time is captured as 00 in that field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_hours_10   <= '0;
      ld_hours_1    <= '0;
      ld_minutes_10 <= '0;
      ld_minutes_1  <= '0;
    end else if (state == RUN && mode_ev) begin
      if (hours_ok(cur_hours_10, cur_hours_1)) begin
        ld_hours_10 <= cur_hours_10;
        ld_hours_1  <= cur_hours_1;
      end else begin
        ld_hours_10 <= '0;
        ld_hours_1  <= '0;
      end
      if (mins_ok(cur_minutes_10, cur_minutes_1)) begin
        ld_minutes_10 <= cur_minutes_10;
        ld_minutes_1  <= cur_minutes_1;
      end else begin
        ld_minutes_10 <= '0;
        ld_minutes_1  <= '0;
      end
    end else if (state == SET_HOUR && inc_ev) begin
      ld_hours_10 <= h10_nx;
      ld_hours_1  <= h1_nx;
    end else if (state == SET_MIN && inc_ev) begin
      ld_minutes_10 <= m10_nx;
      ld_minutes_1  <= m1_nx;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: setting, wrap, timeout,
// tie-break, held button and reset cases.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] cur_hours_10 = 2'd1;
  logic [3:0] cur_hours_1 = 4'd4;
  logic [2:0] cur_minutes_10 = 3'd3;
  logic [3:0] cur_minutes_1 = 4'd7;
  logic       run_en, load, blink;
  logic [1:0] ld_hours_10, field_sel;
  logic [3:0] ld_hours_1, ld_minutes_1;
  logic [2:0] ld_minutes_10;

  int         total = 0;
  int         passed = 0;
  int         loads = 0;
  logic [5:0] ld_h_at = '0;
  logic [6:0] ld_m_at = '0;

  wire [5:0] hrs  = {ld_hours_10, ld_hours_1};
  wire [6:0] mins = {ld_minutes_10, ld_minutes_1};

  time_set_ctrl #(.TIMEOUT_S(30)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_1hz       (tick_1hz),
    .btn_mode       (btn_mode),
    .btn_inc        (btn_inc),
    .cur_hours_10   (cur_hours_10),
    .cur_hours_1    (cur_hours_1),
    .cur_minutes_10 (cur_minutes_10),
    .cur_minutes_1  (cur_minutes_1),
    .run_en         (run_en),
    .load           (load),
    .ld_hours_10    (ld_hours_10),
    .ld_hours_1     (ld_hours_1),
    .ld_minutes_10  (ld_minutes_10),
    .ld_minutes_1   (ld_minutes_1),
    .field_sel      (field_sel),
    .blink          (blink)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      loads   <= loads + 1;
      ld_h_at <= hrs;
      ld_m_at <= mins;
    end
  end

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    step();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
      step();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
    end
  endtask

  initial begin
    step();
    step();
    check("rst_run_en", 16'(run_en), 16'd1);
    check("rst_load", 16'(load), 16'd0);
    check("rst_field", 16'(field_sel), 16'd0);
    check("rst_blink", 16'(blink), 16'd0);
    check("rst_ld", {3'd0, hrs, mins}, 16'd0);
    rst_n = 1'b1;
    step();

    ticks(3);
    check("idle_run_en", 16'(run_en), 16'd1);
    check("idle_blink", 16'(blink), 16'd0);
    check("idle_field", 16'(field_sel), 16'd0);
    check("idle_loads", 16'(loads), 16'd0);

    press_mode();
    check("cap_field", 16'(field_sel), 16'd1);
    check("cap_run_en", 16'(run_en), 16'd0);
    check("cap_hrs", 16'(hrs), 16'h14);
    check("cap_mins", 16'(mins), 16'h37);
    ticks(1);
    check("blink_on", 16'(blink), 16'd1);
    press_inc(3);
    check("hrs_17", 16'(hrs), 16'h17);
    press_mode();
    check("min_field", 16'(field_sel), 16'd2);
    press_inc(25);
    check("mins_02", 16'(mins), 16'h02);
    check("mins_hrs", 16'(hrs), 16'h17);
    check("set_run_en", 16'(run_en), 16'd0);
    btn_mode = 1'b1;
    step();
    check("commit_load", 16'(load), 16'd1);
    check("commit_run_en", 16'(run_en), 16'd0);
    check("commit_field", 16'(field_sel), 16'd0);
    btn_mode = 1'b0;
    step();
    check("post_load", 16'(load), 16'd0);
    check("post_run_en", 16'(run_en), 16'd1);
    step();
    step();
    check("load_count1", 16'(loads), 16'd1);
    check("load_hrs", 16'(ld_h_at), 16'h17);
    check("load_mins", 16'(ld_m_at), 16'h02);

    cur_hours_10 = 2'd2;
    cur_hours_1 = 4'd2;
    cur_minutes_10 = 3'd5;
    cur_minutes_1 = 4'd8;
    press_mode();
    press_inc(1);
    check("hrs_23", 16'(hrs), 16'h23);
    press_inc(1);
    check("hrs_00", 16'(hrs), 16'h00);
    press_mode();
    press_inc(1);
    check("mins_59", 16'(mins), 16'h59);
    press_inc(1);
    check("mins_00", 16'(mins), 16'h00);
    check("no_carry", 16'(hrs), 16'h00);
    press_mode();
    check("load_count2", 16'(loads), 16'd2);

    cur_hours_10 = 2'd1;
    cur_hours_1 = 4'd0;
    cur_minutes_10 = 3'd0;
    cur_minutes_1 = 4'd0;
    press_mode();
    ticks(29);
    check("to29_field", 16'(field_sel), 16'd1);
    ticks(1);
    check("to30_field", 16'(field_sel), 16'd0);
    check("to30_run_en", 16'(run_en), 16'd1);
    check("to30_loads", 16'(loads), 16'd2);
    press_mode();
    ticks(29);
    press_inc(1);
    ticks(29);
    check("restart_field", 16'(field_sel), 16'd1);
    check("restart_hrs", 16'(hrs), 16'h11);
    ticks(1);
    check("restart_to", 16'(field_sel), 16'd0);
    check("restart_loads", 16'(loads), 16'd2);

    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step();
    check("tie_field", 16'(field_sel), 16'd2);
    check("tie_hrs", 16'(hrs), 16'h10);
    btn_inc = 1'b1;
    repeat (100) step();
    btn_inc = 1'b0;
    step();
    check("held_mins", 16'(mins), 16'h01);

    rst_n = 1'b0;
    #1;
    check("arst_field", 16'(field_sel), 16'd0);
    check("arst_run_en", 16'(run_en), 16'd1);
    check("arst_ld", {3'd0, hrs, mins}, 16'd0);
    step();
    rst_n = 1'b1;
    step();
    press_mode();
    press_mode();
    btn_mode = 1'b1;
    step();
    check("pre_rst_load", 16'(load), 16'd1);
    rst_n = 1'b0;
    #1;
    check("crst_load", 16'(load), 16'd0);
    check("crst_run_en", 16'(run_en), 16'd1);
    check("crst_hrs", 16'(hrs), 16'h00);
    btn_mode = 1'b0;
    step();
    check("crst_loads", 16'(loads), 16'd2);
    rst_n = 1'b1;
    step();

    cur_hours_10 = 2'd2;
    cur_hours_1 = 4'd7;
    cur_minutes_10 = 3'd7;
    cur_minutes_1 = 4'd5;
    press_mode();
    check("clamp_field", 16'(field_sel), 16'd1);
    check("clamp_ld", {3'd0, hrs, mins}, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
